// File: rtl/sap1_pkg.sv
// Shared SAP-1 control-word encoding, load mask and opcode numbers.
package sap1_pkg;

   localparam int CONTROL_WORD_WIDTH = 17;
   typedef logic [CONTROL_WORD_WIDTH-1:0] cw_t;

   localparam cw_t c_HLT = cw_t'(1) << 16;
   localparam cw_t c_MI  = cw_t'(1) << 15;
   localparam cw_t c_RI  = cw_t'(1) << 14;
   localparam cw_t c_RO  = cw_t'(1) << 13;
   localparam cw_t c_IO  = cw_t'(1) << 12;
   localparam cw_t c_II  = cw_t'(1) << 11;
   localparam cw_t c_AI  = cw_t'(1) << 10;
   localparam cw_t c_AO  = cw_t'(1) << 9;
   localparam cw_t c_EO  = cw_t'(1) << 8;
   localparam cw_t c_SU  = cw_t'(1) << 7;
   localparam cw_t c_BI  = cw_t'(1) << 6;
   localparam cw_t c_OI  = cw_t'(1) << 5;
   localparam cw_t c_CE  = cw_t'(1) << 4;
   localparam cw_t c_CO  = cw_t'(1) << 3;
   localparam cw_t c_J   = cw_t'(1) << 2;
   localparam cw_t c_EL  = cw_t'(1) << 1;
   localparam cw_t c_ADV = cw_t'(1) << 0;

   // Everything that changes machine state; suppressed while a RAM access waits.
   localparam cw_t LOAD_MASK = c_MI | c_II | c_AI | c_BI | c_OI | c_CE | c_J | c_EL | c_ADV | c_HLT;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_LDI  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_SUBI = 4'h6;
   localparam logic [3:0] OP_STA  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JIZ  = 4'h9;
   localparam logic [3:0] OP_JIC  = 4'hA;
   localparam logic [3:0] OP_JIO  = 4'hB;
   localparam logic [3:0] OP_JNZ  = 4'hC;
   localparam logic [3:0] OP_JNC  = 4'hD;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/microcode_rom.sv
// Pure combinational micro-program decode of (opcode, step, latched flags).
module microcode_rom
   import sap1_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4,
   parameter int STEP_WIDTH   = 3
) (
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic [STEP_WIDTH-1:0]   step_i,
   input  logic [2:0]              flags_i,
   output cw_t                     dec_o
);
   logic [3:0]  op;
   logic [31:0] s;
   logic        zero, carry, odd;

   if (OPCODE_WIDTH > 4) begin : g_wide_op
      assign op = (|opcode_i[OPCODE_WIDTH-1:4]) ? OP_NOP : opcode_i[3:0];
   end else begin : g_narrow_op
      assign op = opcode_i[3:0];
   end

   assign {odd, carry, zero} = flags_i;

   always_comb begin
      dec_o = '0;
      // Widened so steps beyond a short counter's range still compare correctly.
      s     = 32'(step_i);
      if (s == 0) begin
         dec_o = c_MI | c_CO;
      end else if (s == 1) begin
         dec_o = c_RO | c_II | c_CE;
      end else begin
         case (op)
            OP_NOP:  if (s == 2) dec_o = c_ADV;
            OP_LDA:  if (s == 2) dec_o = c_IO | c_MI;
                     else if (s == 3) dec_o = c_RO | c_AI | c_ADV;
            OP_ADD:  if (s == 2) dec_o = c_IO | c_MI;
                     else if (s == 3) dec_o = c_RO | c_BI;
                     else if (s == 4) dec_o = c_EO | c_AI | c_EL | c_ADV;
            OP_SUB:  if (s == 2) dec_o = c_IO | c_MI;
                     else if (s == 3) dec_o = c_RO | c_BI;
                     else if (s == 4) dec_o = c_EO | c_AI | c_SU | c_EL | c_ADV;
            OP_LDI:  if (s == 2) dec_o = c_IO | c_AI | c_ADV;
            OP_ADDI: if (s == 2) dec_o = c_IO | c_BI;
                     else if (s == 3) dec_o = c_EO | c_AI | c_EL | c_ADV;
            OP_SUBI: if (s == 2) dec_o = c_IO | c_BI;
                     else if (s == 3) dec_o = c_EO | c_AI | c_SU | c_EL | c_ADV;
            OP_STA:  if (s == 2) dec_o = c_IO | c_MI;
                     else if (s == 3) dec_o = c_AO | c_RI | c_ADV;
            OP_JMP:  if (s == 2) dec_o = c_IO | c_J | c_ADV;
            OP_JIZ:  if (s == 2) dec_o = (zero   ? (c_IO | c_J) : '0) | c_ADV;
            OP_JIC:  if (s == 2) dec_o = (carry  ? (c_IO | c_J) : '0) | c_ADV;
            OP_JIO:  if (s == 2) dec_o = (odd    ? (c_IO | c_J) : '0) | c_ADV;
            OP_JNZ:  if (s == 2) dec_o = (!zero  ? (c_IO | c_J) : '0) | c_ADV;
            OP_JNC:  if (s == 2) dec_o = (!carry ? (c_IO | c_J) : '0) | c_ADV;
            OP_OUT:  if (s == 2) dec_o = c_AO | c_OI | c_ADV;
            OP_HLT:  if (s == 2) dec_o = c_HLT;
            default: dec_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/microcode_sequencer.sv
// Clocked microcode sequencer: step counter, latched ALU flags, halt and run/single-step control.
// Control word is combinational from the current step; RAM accesses stall until i_mem_ready.
module microcode_sequencer
   import sap1_pkg::*;
#(
   parameter int OPCODE_WIDTH      = 4,
   parameter int INSTRUCTION_STEPS = 8,
   parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic [OPCODE_WIDTH-1:0]       i_opcode,
   input  logic                          i_zero,
   input  logic                          i_carry,
   input  logic                          i_odd,
   input  logic                          i_mem_ready,
   input  logic                          i_run,
   input  logic                          i_step_pulse,
   output logic [CONTROL_WORD_WIDTH-1:0] o_control_word,
   output logic [STEP_WIDTH-1:0]         o_step,
   output logic [2:0]                    o_flags,
   output logic                          o_halted,
   output logic                          o_step_overflow
);
   localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

   cw_t                   dec;
   logic [STEP_WIDTH-1:0] step_q, step_d;
   logic [2:0]            flags_q, flags_d;
   logic                  halted_q, halted_d;
   logic                  ovf_q, ovf_d;
   logic                  pend_q, pend_d;
   logic                  pend, active, stall, en;

   microcode_rom #(
      .OPCODE_WIDTH(OPCODE_WIDTH),
      .STEP_WIDTH  (STEP_WIDTH)
   ) u_rom (
      .opcode_i(i_opcode),
      .step_i  (step_q),
      .flags_i (flags_q),
      .dec_o   (dec)
   );

   always_comb begin
      // A fresh pulse counts in its own cycle; a stalled one is held until it executes.
      pend   = pend_q | (i_step_pulse & ~i_run & ~halted_q);
      active = (i_run | pend) & ~halted_q;
      stall  = ((dec & (c_RO | c_RI)) != '0) & ~i_mem_ready;
      en     = active & ~stall;

      if (!active)     o_control_word = '0;
      else if (stall)  o_control_word = dec & ~LOAD_MASK;
      else             o_control_word = dec;

      step_d   = step_q;
      flags_d  = flags_q;
      halted_d = halted_q;
      ovf_d    = ovf_q;
      pend_d   = pend & ~en;
      if (en) begin
         if ((dec & c_HLT) != '0) begin
            halted_d = 1'b1;
         end else if ((dec & c_ADV) != '0) begin
            step_d = '0;
         end else if (step_q == LAST_STEP) begin
            step_d = '0;
            ovf_d  = 1'b1;
         end else begin
            step_d = step_q + 1'b1;
         end
         if ((dec & c_EL) != '0) flags_d = {i_odd, i_carry, i_zero};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         step_q   <= '0;
         flags_q  <= '0;
         halted_q <= 1'b0;
         ovf_q    <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         step_q   <= step_d;
         flags_q  <= flags_d;
         halted_q <= halted_d;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
      end
   end

   assign o_step          = step_q;
   assign o_flags         = flags_q;
   assign o_halted        = halted_q;
   assign o_step_overflow = ovf_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed vector bench for microcode_sequencer (8-step instance) plus a 4-step wrap sequence.
module tb_microcode_sequencer;
   import sap1_pkg::*;

   typedef struct {
      logic       rst_n;
      logic [3:0] op;
      logic       run, pulse, rdy;
      logic [2:0] live;   // {odd, carry, zero}
      cw_t        cw;
      logic [7:0] step;
      logic [2:0] flags;
      logic       halt, ovf;
   } vec_t;

   localparam cw_t MC = c_MI | c_CO;
   localparam cw_t FE = c_RO | c_II | c_CE;

   logic       clk = 1'b0;
   logic       rst_n, run, pulse, rdy, zero, carry, odd;
   logic [3:0] op;
   logic       run4;
   logic [3:0] op4;
   logic       nopulse = 1'b0;

   cw_t        cw, cw4;
   logic [2:0] step, flags, flags4;
   logic [1:0] step4;
   logic       halted, ovf, halted4, ovf4;

   int applied = 0;
   int miscompares = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   microcode_sequencer #(.OPCODE_WIDTH(4), .INSTRUCTION_STEPS(8)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_opcode(op),
      .i_zero(zero), .i_carry(carry), .i_odd(odd),
      .i_mem_ready(rdy), .i_run(run), .i_step_pulse(pulse),
      .o_control_word(cw), .o_step(step), .o_flags(flags),
      .o_halted(halted), .o_step_overflow(ovf)
   );

   microcode_sequencer #(.OPCODE_WIDTH(4), .INSTRUCTION_STEPS(4)) dut4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_opcode(op4),
      .i_zero(zero), .i_carry(carry), .i_odd(odd),
      .i_mem_ready(rdy), .i_run(run4), .i_step_pulse(nopulse),
      .o_control_word(cw4), .o_step(step4), .o_flags(flags4),
      .o_halted(halted4), .o_step_overflow(ovf4)
   );

   function automatic void v(input logic r, input logic [3:0] o, input logic rn, input logic p,
                             input logic rd, input logic [2:0] lv, input cw_t w,
                             input logic [7:0] s, input logic [2:0] f, input logic h,
                             input logic ov);
      vec_t e;
      e.rst_n = r; e.op = o; e.run = rn; e.pulse = p; e.rdy = rd; e.live = lv;
      e.cw = w; e.step = s; e.flags = f; e.halt = h; e.ovf = ov;
      tbl.push_back(e);
   endfunction

   task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got cw=%h step=%0d flags=%b halt=%b ovf=%b, want cw=%h step=%0d flags=%b halt=%b ovf=%b",
                  name, act[29:13], act[12:5], act[4:2], act[1], act[0],
                  exp[29:13], exp[12:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      // reset state, LDI free run
      v(1,4'h4,0,0,1,3'b000, '0,                    0,3'b000,0,0);
      v(1,4'h4,1,0,1,3'b000, MC,                    0,3'b000,0,0);
      v(1,4'h4,1,0,1,3'b000, FE,                    1,3'b000,0,0);
      v(1,4'h4,1,0,1,3'b000, c_IO|c_AI|c_ADV,       2,3'b000,0,0);
      // ADD with three stall cycles at step 3
      v(1,4'h2,1,0,1,3'b000, MC,                    0,3'b000,0,0);
      v(1,4'h2,1,0,1,3'b000, FE,                    1,3'b000,0,0);
      v(1,4'h2,1,0,1,3'b000, c_IO|c_MI,             2,3'b000,0,0);
      v(1,4'h2,1,0,0,3'b000, c_RO,                  3,3'b000,0,0);
      v(1,4'h2,1,0,0,3'b000, c_RO,                  3,3'b000,0,0);
      v(1,4'h2,1,0,0,3'b000, c_RO,                  3,3'b000,0,0);
      v(1,4'h2,1,0,1,3'b000, c_RO|c_BI,             3,3'b000,0,0);
      v(1,4'h2,1,0,1,3'b011, c_EO|c_AI|c_EL|c_ADV,  4,3'b000,0,0);
      // latched zero=1, live zero disagrees
      v(1,4'h9,1,0,1,3'b000, MC,                    0,3'b011,0,0);
      v(1,4'h9,1,0,1,3'b001, FE,                    1,3'b011,0,0);
      v(1,4'h9,1,0,1,3'b000, c_IO|c_J|c_ADV,        2,3'b011,0,0);
      v(1,4'hC,1,0,1,3'b000, MC,                    0,3'b011,0,0);
      v(1,4'hC,1,0,1,3'b000, FE,                    1,3'b011,0,0);
      v(1,4'hC,1,0,1,3'b000, c_ADV,                 2,3'b011,0,0);
      // ADDI latches odd=1, carry=0, zero=0
      v(1,4'h5,1,0,1,3'b000, MC,                    0,3'b011,0,0);
      v(1,4'h5,1,0,1,3'b000, FE,                    1,3'b011,0,0);
      v(1,4'h5,1,0,1,3'b000, c_IO|c_BI,             2,3'b011,0,0);
      v(1,4'h5,1,0,1,3'b100, c_EO|c_AI|c_EL|c_ADV,  3,3'b011,0,0);
      // latched zero=0/carry=0, live flags held high
      v(1,4'h9,1,0,1,3'b001, MC,                    0,3'b100,0,0);
      v(1,4'h9,1,0,1,3'b001, FE,                    1,3'b100,0,0);
      v(1,4'h9,1,0,1,3'b001, c_ADV,                 2,3'b100,0,0);
      v(1,4'hC,1,0,1,3'b001, MC,                    0,3'b100,0,0);
      v(1,4'hC,1,0,1,3'b001, FE,                    1,3'b100,0,0);
      v(1,4'hC,1,0,1,3'b001, c_IO|c_J|c_ADV,        2,3'b100,0,0);
      v(1,4'hD,1,0,1,3'b010, MC,                    0,3'b100,0,0);
      v(1,4'hD,1,0,1,3'b010, FE,                    1,3'b100,0,0);
      v(1,4'hD,1,0,1,3'b010, c_IO|c_J|c_ADV,        2,3'b100,0,0);
      // single step, one advance per pulse
      v(1,4'h4,0,0,1,3'b000, '0,                    0,3'b100,0,0);
      v(1,4'h4,0,1,1,3'b000, MC,                    0,3'b100,0,0);
      v(1,4'h4,0,0,1,3'b000, '0,                    1,3'b100,0,0);
      v(1,4'h4,0,1,1,3'b000, FE,                    1,3'b100,0,0);
      v(1,4'h4,0,0,1,3'b000, '0,                    2,3'b100,0,0);
      v(1,4'h4,0,1,1,3'b000, c_IO|c_AI|c_ADV,       2,3'b100,0,0);
      // LDA single-stepped, pulse lands in a stall and executes once
      v(1,4'h1,0,1,1,3'b000, MC,                    0,3'b100,0,0);
      v(1,4'h1,0,1,1,3'b000, FE,                    1,3'b100,0,0);
      v(1,4'h1,0,1,1,3'b000, c_IO|c_MI,             2,3'b100,0,0);
      v(1,4'h1,0,1,0,3'b000, c_RO,                  3,3'b100,0,0);
      v(1,4'h1,0,0,0,3'b000, c_RO,                  3,3'b100,0,0);
      v(1,4'h1,0,1,0,3'b000, c_RO,                  3,3'b100,0,0);
      v(1,4'h1,0,0,1,3'b000, c_RO|c_AI|c_ADV,       3,3'b100,0,0);
      v(1,4'h1,0,0,1,3'b000, '0,                    0,3'b100,0,0);
      // run dropped mid-instruction freezes the step
      v(1,4'h2,1,0,1,3'b000, MC,                    0,3'b100,0,0);
      v(1,4'h2,0,0,1,3'b000, '0,                    1,3'b100,0,0);
      v(1,4'h2,1,0,1,3'b000, FE,                    1,3'b100,0,0);
      // HLT, then only reset recovers
      v(1,4'hF,1,0,1,3'b000, c_HLT,                 2,3'b100,0,0);
      v(1,4'hF,1,0,1,3'b000, '0,                    2,3'b100,1,0);
      v(1,4'hF,0,1,1,3'b000, '0,                    2,3'b100,1,0);
      v(1,4'hF,1,0,1,3'b000, '0,                    2,3'b100,1,0);
      v(0,4'hF,1,0,1,3'b000, '0,                    2,3'b100,1,0);
      v(1,4'h4,1,0,1,3'b000, MC,                    0,3'b000,0,0);

      rst_n = 1'b0; run = 1'b0; pulse = 1'b0; rdy = 1'b1; op = 4'h0;
      zero = 1'b0; carry = 1'b0; odd = 1'b0; run4 = 1'b0; op4 = 4'h2;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n; op = tbl[i].op; run = tbl[i].run;
         pulse = tbl[i].pulse; rdy = tbl[i].rdy;
         {odd, carry, zero} = tbl[i].live;
         #2;
         check($sformatf("vec%0d", i), {cw, 8'(step), flags, halted, ovf},
               {tbl[i].cw, tbl[i].step, tbl[i].flags, tbl[i].halt, tbl[i].ovf});
         @(posedge clk);
         #1;
      end

      // 4-step instance: ADD never reaches its c_EL step and wraps instead
      begin
         cw_t exp_cw [4];
         exp_cw[0] = MC; exp_cw[1] = FE; exp_cw[2] = c_IO | c_MI; exp_cw[3] = c_RO | c_BI;
         run = 1'b0; pulse = 1'b0; rdy = 1'b1; zero = 1'b1; carry = 1'b1; odd = 1'b1;
         run4 = 1'b1; op4 = 4'h2;
         for (int k = 0; k < 9; k++) begin
            #2;
            check($sformatf("wrap%0d", k), {cw4, 8'(step4), flags4, halted4, ovf4},
                  {exp_cw[k % 4], 8'(k % 4), 3'b000, 1'b0, (k >= 4) ? 1'b1 : 1'b0});
            @(posedge clk);
            #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
